fsm_moore_0110: RTL and testbench

- Moore-type serial sequence detector for the bit pattern 0-1-1-0 on a 1-bit input stream sampled on each rising clock edge.
- Output z is a pure function of the current state and is asserted for exactly one clock cycle after the final 0 of the pattern has been sampled.
- Intended as a small control-path leaf block. It is typically placed behind a synchronizer on a serial data line.

---
 rtl/fsm_moore_0110.sv | 52 +++++
 tb/tb_fsm_moore_0110.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fsm_moore_0110.sv
// Moore detector for serial pattern 0-1-1-0; z is high for the one cycle after the final 0 is sampled.
// z decodes only the state register, so x has no combinational path to it; no flow control.
module fsm_moore_0110 #(
    parameter bit OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic x,
    output logic z
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_S0     = 3'd1;
    localparam logic [2:0] ST_S01    = 3'd2;
    localparam logic [2:0] ST_S011   = 3'd3;
    localparam logic [2:0] ST_DETECT = 3'd4;

    logic [2:0] state_q;
    logic [2:0] state_d;

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:   state_d = x ? ST_IDLE : ST_S0;
            ST_S0:     state_d = x ? ST_S01  : ST_S0;
            ST_S01:    state_d = x ? ST_S011 : ST_S0;
            ST_S011:   state_d = x ? ST_IDLE : ST_DETECT;
            // The trailing 0 of a hit is itself a "0" prefix; overlap also reuses it before a 1.
            ST_DETECT: begin
                if (!x) begin
                    state_d = ST_S0;
                end else if (OVERLAP) begin
                    state_d = ST_S01;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign z = (state_q == ST_DETECT);

endmodule

// File: tb/tb_fsm_moore_0110.sv
// Randomised scoreboard bench: both OVERLAP settings run on one stream against a bit-history model.
module tb_fsm_moore_0110;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic x     = 1'b0;
    logic z_ov;
    logic z_no;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses_ov = 0;
    int pulses_no = 0;

    typedef struct packed {
        logic z_ov;
        logic z_no;
    } exp_t;

    exp_t exp_q[$];
    bit   hist_ov[$];
    bit   hist_no[$];

    fsm_moore_0110 #(.OVERLAP(1'b1)) u_dut_ov (
        .clk   (clk),
        .reset (reset),
        .x     (x),
        .z     (z_ov)
    );

    fsm_moore_0110 #(.OVERLAP(1'b0)) u_dut_no (
        .clk   (clk),
        .reset (reset),
        .x     (x),
        .z     (z_no)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic bit ends_in_0110(input bit h[$]);
        if (h.size() < 4) return 1'b0;
        return (h[h.size()-4] == 1'b0) && (h[h.size()-3] == 1'b1) &&
               (h[h.size()-2] == 1'b1) && (h[h.size()-1] == 1'b0);
    endfunction

    // Reference: a hit is "last four bits since the search (re)started are 0110".
    always @(posedge clk) begin
        if (reset) begin
            exp_t e;
            hist_ov.push_back(x);
            hist_no.push_back(x);
            if (hist_ov.size() > 4) void'(hist_ov.pop_front());
            if (hist_no.size() > 4) void'(hist_no.pop_front());
            e.z_ov = ends_in_0110(hist_ov);
            e.z_no = ends_in_0110(hist_no);
            if (e.z_no) hist_no.delete();
            exp_q.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("z_ov_in_reset", z_ov, 1'b0);
            chk("z_no_in_reset", z_no, 1'b0);
        end else if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("z_ov", z_ov, e.z_ov);
            chk("z_no", z_no, e.z_no);
            if (z_ov === 1'b1) pulses_ov++;
            if (z_no === 1'b1) pulses_no++;
        end
    end

    // Called between edges; releases reset 6 ns after a rising edge with x=0.
    task automatic do_reset(input int ncyc);
        reset = 1'b0;
        #1;
        chk("z_ov_async_reset", z_ov, 1'b0);
        chk("z_no_async_reset", z_no, 1'b0);
        exp_q.delete();
        hist_ov.delete();
        hist_no.delete();
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #2 x = (i % 2 == 0) ? 1'bx : 1'b1;
        end
        @(posedge clk);
        #6;
        x     = 1'b0;
        reset = 1'b1;
    endtask

    task automatic send(input logic b);
        x = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_seq(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) send(bits[i]);
    endtask

    initial begin
        reset = 1'b0;
        #1;
        do_reset(2);

        // Basic hit then a trailing 0
        send_seq(16'b01100, 5);
        // No false hits
        send_seq(16'b000111010, 9);
        send(1'b1); send(1'b1);

        // Back-to-back: two pulses with overlap, one without
        do_reset(1);
        pulses_ov = 0;
        pulses_no = 0;
        send_seq(16'b0110110, 7);
        send(1'b1);
        @(negedge clk);
        #1;
        chk_int("pulses_ov_0110110", pulses_ov, 2);
        chk_int("pulses_no_0110110", pulses_no, 1);

        // Reset mid-pattern discards the prefix
        send(1'b1);
        send_seq(16'b011, 3);
        #2 reset = 1'b0;
        #1;
        chk("z_ov_mid_reset", z_ov, 1'b0);
        exp_q.delete(); hist_ov.delete(); hist_no.delete();
        #2 reset = 1'b1;
        send(1'b0);
        send(1'b0);

        // Reset while z is high drops it before the next edge
        send_seq(16'b0110, 4);
        #5;
        chk("z_ov_before_reset", z_ov, 1'b1);
        do_reset(1);

        // Narrow pulse between edges is ignored
        send(1'b0);
        #2 x = 1'b1;
        #4 x = 1'b0;
        @(posedge clk); #1;
        send(1'b0);
        send(1'b0);

        // Random stream with occasional resets and glitches
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                #1 do_reset($urandom_range(1, 3));
            end else if ($urandom_range(0, 49) == 0) begin
                x = 1'b0;
                #2 x = 1'b1;
                #4 x = 1'b0;
                @(posedge clk); #1;
            end else begin
                send(($urandom_range(0, 2) == 0) ? 1'b1 : logic'($urandom_range(0, 1)));
            end
        end

        repeat (2) @(negedge clk);
        #1;
        chk_int("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
